python_align_ctrl: RTL
======================

Name: python_align_ctrl

Overview:
- Word-alignment training controller for the PYTHON LVDS 10-bit receiver; runs in the receiver's divided (BUFR) clock domain.
- Watches the deserialised sync-channel word while the sensor transmits its idle training pattern.
- Pulses the shared ISERDES bitslip until the pattern is seen for a run of consecutive words, then reports lock.
- Gives software a deterministic aligned/fail status and a slip count; retraining is triggered by request.

Parameters:
- TRAIN_PATTERN, 10'h3A6: expected 10-bit idle training word on the sync channel.
- MATCH_COUNT, 16: consecutive matching words required to declare lock (1..255).
- SLIP_WAIT, 4: cycles to wait after reset release or a bitslip pulse before comparing again (ISERDES bitslip latency); 1..15.
- MAX_SLIPS, 10: bitslip pulses allowed before declaring failure (1..15).

Ports:
- clk, input, 1: receiver divided clock (same clock as the deserialised data).
- reset, input, 1: synchronous, active-high.
- enable, input, 1: level; low forces IDLE.
- restart, input, 1: single-cycle pulse; restarts training from any state.
- in_sync, input, 10: deserialised sync-channel word, valid every cycle.
- bitslip, output, 1: single-cycle pulse to all ISERDES BITSLIP inputs.
- aligned, output, 1: high only in LOCKED.
- error, output, 1: high only in FAIL.
- busy, output, 1: high in WAIT, CHECK or SLIP.
- slip_count, output, 4: bitslip pulses issued since training start.

Behaviour:
- Reset: state=IDLE; bitslip=0, aligned=0, error=0, busy=0, slip_count=0; internal match and wait counters = 0.
- All outputs are registered; one-cycle latency from state entry.
- IDLE: when enable=1, go to WAIT with wait counter=SLIP_WAIT-1, slip_count=0, match=0.
- WAIT: decrement the wait counter; on 0, go to CHECK. in_sync is ignored.
- CHECK: compare in_sync with TRAIN_PATTERN.
  - Match: match+1; when match reaches MATCH_COUNT (i.e. the MATCH_COUNT-th consecutive match), go to LOCKED.
  - Mismatch with slip_count<MAX_SLIPS: go to SLIP, match=0.
  - Mismatch with slip_count==MAX_SLIPS: go to FAIL.
- SLIP: bitslip=1 for exactly this one cycle; slip_count+1; go to WAIT with wait counter=SLIP_WAIT-1.
- LOCKED: hold. in_sync is not monitored; frame codes are legal on the sync channel.
- FAIL: hold, error=1.
- restart=1 in any state with enable=1: next state WAIT, counters cleared as on IDLE exit; same cycle as any other transition, restart wins.
- enable=0 in any state: next state IDLE; enable has priority over restart. A SLIP cycle already in progress still completes its single pulse; the next state is IDLE.
- reset has priority over everything, including mid-pulse: bitslip drops the next cycle.
- Consecutive bitslip pulses are always separated by at least SLIP_WAIT+1 low cycles.
- slip_count saturates at MAX_SLIPS, because FAIL is reached before any further slip.
- Match counter width: $clog2(MATCH_COUNT+1). It never wraps; it resets on mismatch or on leaving CHECK.

Decomposition:
- Package python_align_pkg holds:
  - state enum (IDLE, WAIT, CHECK, SLIP, LOCKED, FAIL), 3-bit, used by the bench for state probing;
  - localparam default training word 10'h3A6;
  - 10-bit word typedef.
- No sub-module; the FSM and three counters fit in one module.

Test Plan:
- Already aligned: enable=1 with in_sync held at 10'h3A6 → no bitslip; aligned=1 after SLIP_WAIT+MATCH_COUNT+2 cycles (22 with defaults); slip_count=0.
- Misaligned by 3: bench model rotates the word once per bitslip and starts 3 slips away → exactly 3 bitslip pulses spaced ≥5 cycles apart; aligned=1; slip_count=3.
- Never matching: in_sync=10'h000 → 10 bitslip pulses; then error=1, aligned=0, slip_count=10; FAIL held for 100 cycles.
- Glitch during match: 10 matches, 1 mismatch, then matches → one bitslip; match count restarts; lock only after 16 further consecutive matches.
- Restart from LOCKED, with pattern now misaligned by 1 → busy=1 and aligned=0 the next cycle; 1 slip, then relock with slip_count=1.
- enable dropped during SLIP, and reset asserted mid-WAIT → bitslip is at most one cycle wide; state reaches IDLE; all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/python_align_ctrl_pkg.sv
// Shared types for the PYTHON LVDS word-alignment controller.
package python_align_pkg;

   typedef logic [9:0] word_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      CHECK  = 3'd2,
      SLIP   = 3'd3,
      LOCKED = 3'd4,
      FAIL   = 3'd5
   } state_t;

   localparam word_t TRAIN_PATTERN_DEFAULT = 10'h3A6;

endpackage

// File: rtl/python_align_ctrl.sv
// Sync-channel word-alignment trainer: bitslips the ISERDES until the idle
// training word is seen MATCH_COUNT times in a row, then reports lock.
module python_align_ctrl
   import python_align_pkg::*;
#(
   parameter word_t TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
   parameter int    MATCH_COUNT   = 16,
   parameter int    SLIP_WAIT     = 4,
   parameter int    MAX_SLIPS     = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       restart,
   input  word_t      in_sync,
   output logic       bitslip,
   output logic       aligned,
   output logic       error,
   output logic       busy,
   output logic [3:0] slip_count
);

   localparam int MW = $clog2(MATCH_COUNT + 1);

   state_t          state, state_n;
   logic [MW-1:0]   match_cnt, match_n;
   logic [3:0]      wait_cnt, wait_n;
   logic [3:0]      slip_cnt, slip_n;

   always_comb begin
      state_n = state;
      match_n = match_cnt;
      wait_n  = wait_cnt;
      slip_n  = slip_cnt;
      case (state)
         IDLE: begin
            if (enable) begin
               state_n = WAIT;
               wait_n  = 4'(SLIP_WAIT - 1);
               slip_n  = '0;
               match_n = '0;
            end
         end
         WAIT: begin
            if (wait_cnt == '0) state_n = CHECK;
            else                wait_n  = wait_cnt - 4'd1;
         end
         CHECK: begin
            if (in_sync == TRAIN_PATTERN) begin
               if (match_cnt == MW'(MATCH_COUNT - 1)) begin
                  state_n = LOCKED;
                  match_n = '0;
               end else begin
                  match_n = match_cnt + MW'(1);
               end
            end else begin
               match_n = '0;
               state_n = (slip_cnt < 4'(MAX_SLIPS)) ? SLIP : FAIL;
            end
         end
         SLIP: begin
            slip_n  = slip_cnt + 4'd1;
            state_n = WAIT;
            wait_n  = 4'(SLIP_WAIT - 1);
         end
         default: ;
      endcase

      // enable beats restart; a SLIP cycle still counts its pulse on the way out
      if (!enable) begin
         state_n = IDLE;
         match_n = '0;
      end else if (restart) begin
         state_n = WAIT;
         wait_n  = 4'(SLIP_WAIT - 1);
         slip_n  = '0;
         match_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         match_cnt  <= '0;
         wait_cnt   <= '0;
         slip_cnt   <= '0;
         bitslip    <= 1'b0;
         aligned    <= 1'b0;
         error      <= 1'b0;
         busy       <= 1'b0;
         slip_count <= '0;
      end else begin
         state      <= state_n;
         match_cnt  <= match_n;
         wait_cnt   <= wait_n;
         slip_cnt   <= slip_n;
         bitslip    <= (state == SLIP);
         aligned    <= (state == LOCKED);
         error      <= (state == FAIL);
         busy       <= (state inside {WAIT, CHECK, SLIP});
         slip_count <= slip_cnt;
      end
   end

endmodule
